inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//   Instruction fetch stage that feeds if_id and the ROM/memory port.
//   Assembles each 32-bit instruction from an 8-bit memory port with 1-cycle read latency.
//   Holds the finished instruction under downstream stall and redirects the PC on jump.
//   Supplies pc_o/inst_o/inst_valid_o to if_id's if_pc/if_inst inputs.
// PARAMETERS
//   RESET_PC  32'h0  PC after reset; must be 4-byte aligned
// PORTS
//   clk          in   1   single clock; all state updates on posedge
//   rst          in   1   asynchronous, active-high reset
//   stall_i      in   1   1 = downstream cannot accept inst_o this cycle
//   jump_i       in   1   1 = redirect fetch to jump_addr_i
//   jump_addr_i  in   32  jump target; bits [1:0] ignored (treated as 00)
//   mem_rd_o     out  1   byte read request this cycle
//   mem_addr_o   out  32  byte address of the request
//   mem_data_i   in   8   data for the request issued in the previous cycle
//   pc_o         out  32  address of the instruction on inst_o
//   inst_o       out  32  assembled instruction, little-endian
//   inst_valid_o out  1   pc_o/inst_o valid
// BEHAVIOUR
//   Reset values (async, immediate):
//   - pc = RESET_PC, state = F0, byte buffer = 0
//   - inst_o = 0, pc_o = RESET_PC, inst_valid_o = 0
//   - mem_rd_o = 0 while rst = 1
//   State machine F0 -> F1 -> F2 -> F3 -> F4 -> VALID:
//   - Fk (k = 0..3): mem_rd_o = 1, mem_addr_o = pc + k (mod 2^32)
//   - F1..F4: capture mem_data_i into byte k-1; byte0 -> inst[7:0], byte3 -> inst[31:24]
//   - F4: mem_rd_o = 0; on the edge, load inst_o = {mem_data_i, b2, b1, b0},
//     set pc_o = pc and inst_valid_o = 1, then go to VALID
//   - VALID: mem_rd_o = 0; inst_o, pc_o and inst_valid_o are held
//   - VALID with stall_i = 1: stay in VALID
//   - VALID with stall_i = 0: instruction accepted; pc <= pc + 4 (wraps), inst_valid_o <= 0, go to F0
//   - outside F0..F3, mem_addr_o = pc
//   Latency and throughput:
//   - inst_valid_o rises 5 cycles after F0 is entered
//   - unstalled throughput is 1 instruction per 6 cycles
//   Jump:
//   - jump_i has priority over every state and over stall_i
//   - on the edge: pc <= {jump_addr_i[31:2], 2'b00}, state <= F0, inst_valid_o <= 0
//   - partially assembled bytes are discarded
//   - an instruction held in VALID is dropped, not delivered
//   - jump_i together with an accept in VALID: the jump wins, pc is not incremented
//   Other rules:
//   - stall_i is ignored outside VALID; fetch proceeds and stall only holds a completed instruction
//   - rst mid-operation: outputs return to reset values immediately; fetch restarts at RESET_PC in F0
//   - inst_o/pc_o change only on entry to VALID or on reset
// TESTING
//   1. Reset; mem[0..3] = 13,05,10,00 -> mem_addr_o 0,1,2,3 in cycles 1-4;
//      cycle 6: inst_valid_o = 1, inst_o = 32'h00100513, pc_o = 0.
//   2. stall_i = 1 for 3 cycles in VALID -> inst_o/pc_o stable, mem_rd_o = 0;
//      after release, next fetch at addresses 4..7 and pc_o = 4.
//   3. jump_i = 1, jump_addr_i = 32'h100 during F2 -> next cycle mem_addr_o = 32'h100;
//      old instruction never valid; next inst_valid_o has pc_o = 32'h100.
//   4. jump_addr_i = 32'h103 -> fetch addresses 32'h100..32'h103.
//   5. Jump to 32'hFFFFFFFC, accept -> next fetch addresses 0,1,2,3 and pc_o = 0.
//   6. rst pulsed mid-F2 -> inst_valid_o = 0 and pc_o = RESET_PC without a clock edge;
//      restart at F0 and first delivered instruction has pc_o = RESET_PC.
//   7. jump_i asserted in VALID with stall_i = 0 -> instruction dropped; pc_o of the next
//      valid instruction = jump target, not pc + 4.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: builds each 32-bit little-endian instruction from four
// byte reads on a 1-cycle-latency memory port, holds it under stall, redirects on jump.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    // state   | meaning
    // S_F0    | request byte 0 at pc
    // S_F1    | request byte 1, capture byte 0
    // S_F2    | request byte 2, capture byte 1
    // S_F3    | request byte 3, capture byte 2
    // S_F4    | no request, byte 3 arrives, instruction loaded on the edge
    // S_VALID | instruction presented, held while stall_i = 1
    typedef enum logic [2:0] {
        S_F0    = 3'd0,
        S_F1    = 3'd1,
        S_F2    = 3'd2,
        S_F3    = 3'd3,
        S_F4    = 3'd4,
        S_VALID = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [7:0]  r_b0;
    logic [7:0]  r_b1;
    logic [7:0]  r_b2;
    logic [31:0] r_inst;
    logic [31:0] r_pc_out;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        w_load;
    logic        w_rd;
    logic [31:0] w_addr;
    logic [31:0] w_jump_pc;

    assign w_jump_pc = jump_addr_i & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_F0;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_load      = 1'b0;
        w_rd        = 1'b0;
        w_addr      = r_pc;
        case (r_state)
            S_F0: begin
                w_rd        = 1'b1;
                w_state_nxt = S_F1;
            end
            S_F1: begin
                w_rd        = 1'b1;
                w_addr      = r_pc + 32'd1;
                w_state_nxt = S_F2;
            end
            S_F2: begin
                w_rd        = 1'b1;
                w_addr      = r_pc + 32'd2;
                w_state_nxt = S_F3;
            end
            S_F3: begin
                w_rd        = 1'b1;
                w_addr      = r_pc + 32'd3;
                w_state_nxt = S_F4;
            end
            S_F4: begin
                w_load      = 1'b1;
                w_valid_nxt = 1'b1;
                w_state_nxt = S_VALID;
            end
            S_VALID: begin
                if (!stall_i) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_F0;
                end
            end
            default: begin
                w_state_nxt = S_F0;
            end
        endcase
        // A jump overrides everything, including an accept or a pending load.
        if (jump_i) begin
            w_pc_nxt    = w_jump_pc;
            w_valid_nxt = 1'b0;
            w_load      = 1'b0;
            w_state_nxt = S_F0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b0 <= 8'h00;
            r_b1 <= 8'h00;
            r_b2 <= 8'h00;
        end else begin
            if (r_state == S_F1) r_b0 <= mem_data_i;
            if (r_state == S_F2) r_b1 <= mem_data_i;
            if (r_state == S_F3) r_b2 <= mem_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst   <= 32'h0;
            r_pc_out <= RESET_PC;
        end else if (w_load) begin
            r_inst   <= {mem_data_i, r_b2, r_b1, r_b0};
            r_pc_out <= r_pc;
        end
    end

    assign mem_rd_o     = w_rd & ~rst;
    assign mem_addr_o   = w_addr;
    assign pc_o         = r_pc_out;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: byte-wide memory model with 1-cycle latency,
// hand-computed fetch addresses and assembled instructions.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_data_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    int passed;
    int total;

    inst_fetch #(.RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0:   mem_byte = 8'h13;
            32'h1:   mem_byte = 8'h05;
            32'h2:   mem_byte = 8'h10;
            32'h3:   mem_byte = 8'h00;
            32'h4:   mem_byte = 8'h93;
            32'h5:   mem_byte = 8'h05;
            32'h6:   mem_byte = 8'h20;
            32'h7:   mem_byte = 8'h00;
            32'h100: mem_byte = 8'hEF;
            32'h101: mem_byte = 8'hBE;
            32'h102: mem_byte = 8'hAD;
            32'h103: mem_byte = 8'hDE;
            default: mem_byte = a[7:0] ^ 8'hA5;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_rd_o) mem_data_i <= mem_byte(mem_addr_o);
        else          mem_data_i <= 8'h00;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the four fetch cycles starting now (state F0), then F4, then VALID.
    task automatic fetch_and_check(input string name, input logic [31:0] base,
                                   input logic [31:0] exp_inst);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem_rd_o !== 1'b1 || mem_addr_o !== base + k || inst_valid_o !== 1'b0)
                $display("FAIL %s fetch%0d: rd=%b addr=%h valid=%b, want rd=1 addr=%h valid=0",
                         name, k, mem_rd_o, mem_addr_o, inst_valid_o, base + k);
            else passed++;
            step();
        end
        total++;
        if (mem_rd_o !== 1'b0 || inst_valid_o !== 1'b0)
            $display("FAIL %s f4: rd=%b valid=%b, want 0 0", name, mem_rd_o, inst_valid_o);
        else passed++;
        step();
        total++;
        if (inst_valid_o !== 1'b1 || inst_o !== exp_inst || pc_o !== base || mem_rd_o !== 1'b0)
            $display("FAIL %s valid: valid=%b inst=%h pc=%h rd=%b, want 1 %h %h 0",
                     name, inst_valid_o, inst_o, pc_o, mem_rd_o, exp_inst, base);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = 32'h0;
        #2;
        total++;
        if (mem_rd_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0)
            $display("FAIL reset: rd=%b valid=%b pc=%h inst=%h, want 0 0 0 0",
                     mem_rd_o, inst_valid_o, pc_o, inst_o);
        else passed++;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_first_fetch();
        fetch_and_check("first", 32'h0, 32'h0010_0513);
        stall_i = 1'b1;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (inst_valid_o !== 1'b1 || inst_o !== 32'h0010_0513 || pc_o !== 32'h0 || mem_rd_o !== 1'b0)
                $display("FAIL stall_hold%0d: valid=%b inst=%h pc=%h rd=%b, want 1 00100513 0 0",
                         i, inst_valid_o, inst_o, pc_o, mem_rd_o);
            else passed++;
        end
        stall_i = 1'b0;
        step();
        fetch_and_check("after_stall", 32'h4, 32'h0020_0593);
        stall_i = 1'b1;
    endtask

    task automatic test_jump_mid_fetch();
        stall_i = 1'b0;
        step();
        stall_i = 1'b1;
        step();
        step();
        total++;
        if (mem_addr_o !== 32'hA || mem_rd_o !== 1'b1)
            $display("FAIL jump_mid_pre: addr=%h rd=%b, want 0000000a 1", mem_addr_o, mem_rd_o);
        else passed++;
        jump_i = 1'b1; jump_addr_i = 32'h100;
        step();
        jump_i = 1'b0;
        fetch_and_check("jump_mid", 32'h100, 32'hDEAD_BEEF);
    endtask

    task automatic test_jump_unaligned();
        jump_i = 1'b1; jump_addr_i = 32'h103;
        step();
        jump_i = 1'b0;
        fetch_and_check("jump_unaligned", 32'h100, 32'hDEAD_BEEF);
    endtask

    task automatic test_wrap();
        jump_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
        step();
        jump_i = 1'b0;
        fetch_and_check("wrap_top", 32'hFFFF_FFFC, 32'h5A5B_5859);
        stall_i = 1'b0;
        step();
        stall_i = 1'b1;
        fetch_and_check("wrap_zero", 32'h0, 32'h0010_0513);
    endtask

    task automatic test_jump_in_valid();
        stall_i = 1'b0;
        jump_i = 1'b1; jump_addr_i = 32'h100;
        step();
        jump_i = 1'b0;
        stall_i = 1'b1;
        total++;
        if (inst_valid_o !== 1'b0 || mem_addr_o !== 32'h100)
            $display("FAIL jump_accept: valid=%b addr=%h, want 0 00000100", inst_valid_o, mem_addr_o);
        else passed++;
        fetch_and_check("jump_accept", 32'h100, 32'hDEAD_BEEF);
    endtask

    task automatic test_reset_mid();
        stall_i = 1'b0;
        step();
        step();
        step();
        total++;
        if (mem_addr_o !== 32'h106)
            $display("FAIL rst_mid_pre: addr=%h, want 00000106", mem_addr_o);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (inst_valid_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0 || mem_rd_o !== 1'b0)
            $display("FAIL rst_mid: valid=%b pc=%h inst=%h rd=%b, want 0 0 0 0",
                     inst_valid_o, pc_o, inst_o, mem_rd_o);
        else passed++;
        step();
        rst = 1'b0;
        stall_i = 1'b1;
        #1;
        fetch_and_check("rst_restart", 32'h0, 32'h0010_0513);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_jump_mid_fetch();
        test_jump_unaligned();
        test_wrap();
        test_jump_in_valid();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
